// File: rtl/aq_axis_reduce_core.sv
// Nearest-neighbour AXI4-Stream down-scaler: per-axis DDA decimation from
// ORG_X x ORG_Y to CNV_X x CNV_Y, one pixel per beat, single registered output.
module aq_axis_reduce_core #(
  parameter int DATA_W = 24
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [15:0]       ORG_X,
  input  logic [15:0]       ORG_Y,
  input  logic [15:0]       CNV_X,
  input  logic [15:0]       CNV_Y,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TUSER,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TUSER,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              LINE_ERR
);

  logic [15:0] org_x_r, org_y_r, cnv_x_r, cnv_y_r;
  logic [15:0] acc_x, acc_y, x_cnt;
  logic        sof_pending, line_keep, in_frame;

  logic        accept, sof, first, frame_ok, emit, len_bad;
  logic [15:0] org_x, org_y, cnv_x, cnv_y;
  logic [15:0] acc_x_cur, acc_y_cur, x_cnt_cur, acc_x_nxt, acc_y_nxt;
  logic [16:0] t_x, t_y;
  logic        byp_x, byp_y, keep_x, keep_y, lk_new;

  assign S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign sof           = S_AXIS_TUSER;

  // The start-of-frame beat sees the live ports and zeroed state.
  assign org_x     = sof ? ORG_X : org_x_r;
  assign org_y     = sof ? ORG_Y : org_y_r;
  assign cnv_x     = sof ? CNV_X : cnv_x_r;
  assign cnv_y     = sof ? CNV_Y : cnv_y_r;
  assign acc_x_cur = sof ? 16'd0 : acc_x;
  assign acc_y_cur = sof ? 16'd0 : acc_y;
  assign x_cnt_cur = sof ? 16'd0 : x_cnt;
  assign first     = sof || (x_cnt == 16'd0);
  assign frame_ok  = sof || in_frame;

  always_comb begin
    byp_x     = (cnv_x == 16'd0) || (cnv_x >= org_x);
    byp_y     = (cnv_y == 16'd0) || (cnv_y >= org_y);
    t_x       = {1'b0, acc_x_cur} + {1'b0, cnv_x};
    t_y       = {1'b0, acc_y_cur} + {1'b0, cnv_y};
    keep_x    = byp_x || (t_x >= {1'b0, org_x});
    lk_new    = byp_y || (t_y >= {1'b0, org_y});
    // True result of t-ORG fits in 16 bits, so modular 16-bit math is exact.
    acc_x_nxt = byp_x ? 16'd0 : (keep_x ? (acc_x_cur + cnv_x - org_x) : t_x[15:0]);
    acc_y_nxt = byp_y ? 16'd0 : (lk_new ? (acc_y_cur + cnv_y - org_y) : t_y[15:0]);
    keep_y    = first ? lk_new : line_keep;
    emit      = frame_ok && keep_x && keep_y;
    len_bad   = ({1'b0, x_cnt_cur} + 17'd1) != {1'b0, org_x};
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      org_x_r     <= '0;
      org_y_r     <= '0;
      cnv_x_r     <= '0;
      cnv_y_r     <= '0;
      acc_x       <= '0;
      acc_y       <= '0;
      x_cnt       <= '0;
      sof_pending <= 1'b0;
      line_keep   <= 1'b0;
      in_frame    <= 1'b0;
      LINE_ERR    <= 1'b0;
    end else begin
      LINE_ERR <= accept && S_AXIS_TLAST && frame_ok && len_bad;
      if (accept) begin
        if (sof) begin
          org_x_r  <= ORG_X;
          org_y_r  <= ORG_Y;
          cnv_x_r  <= CNV_X;
          cnv_y_r  <= CNV_Y;
          in_frame <= 1'b1;
        end
        acc_x <= S_AXIS_TLAST ? 16'd0 : acc_x_nxt;
        x_cnt <= S_AXIS_TLAST ? 16'd0 : x_cnt_cur + 16'd1;
        if (first) begin
          acc_y     <= acc_y_nxt;
          line_keep <= lk_new;
        end
        sof_pending <= emit ? 1'b0 : (sof || sof_pending);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (accept && emit) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= S_AXIS_TDATA;
      M_AXIS_TUSER  <= sof || sof_pending;
      M_AXIS_TLAST  <= S_AXIS_TLAST;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aq_axis_reduce_core.sv
// Randomized bench for aq_axis_reduce_core against a ratio-based reference model.
module tb_aq_axis_reduce_core;
  localparam int DATA_W = 24;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [15:0]       ORG_X = '0, ORG_Y = '0, CNV_X = '0, CNV_Y = '0;
  logic [DATA_W-1:0] S_AXIS_TDATA = '0;
  logic              S_AXIS_TUSER = 1'b0, S_AXIS_TLAST = 1'b0, S_AXIS_TVALID = 1'b0;
  logic              S_AXIS_TREADY;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID;
  logic              M_AXIS_TREADY = 1'b1;
  logic              LINE_ERR;

  aq_axis_reduce_core #(.DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .LINE_ERR(LINE_ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              u, l;
    logic [15:0]       ox, oy, cx, cy;
  } beat_t;

  beat_t       bq[$];
  logic [25:0] eq[$];
  int total = 0, bad = 0;

  // reference model state
  bit          m_in = 0, m_sof = 0;
  int          m_x = 0, m_y = 0, exp_err = 0;
  int          mox = 0, moy = 0, mcx = 0, mcy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Index i survives decimation o->c when the ideal scaled coordinate crosses an integer.
  function automatic bit keep_ax(input int i, input int o, input int c);
    if (c == 0 || c >= o) return 1'b1;
    return ((i + 1) * c) / o > (i * c) / o;
  endfunction

  task automatic push(input logic [DATA_W-1:0] d, input bit u, input bit l,
                      input int ox, input int oy, input int cx, input int cy);
    beat_t b;
    b.d = d; b.u = u; b.l = l;
    b.ox = 16'(ox); b.oy = 16'(oy); b.cx = 16'(cx); b.cy = 16'(cy);
    bq.push_back(b);
    if (u) begin
      m_in = 1; m_sof = 1; m_x = 0; m_y = 0;
      mox = ox; moy = oy; mcx = cx; mcy = cy;
    end
    if (m_in && keep_ax(m_x, mox, mcx) && keep_ax(m_y, moy, mcy)) begin
      eq.push_back({l, m_sof, d});
      m_sof = 0;
    end
    if (l) begin
      if (m_in && m_x + 1 != mox) exp_err++;
      m_x = 0;
      m_y++;
    end else begin
      m_x++;
    end
  endtask

  // Non-SOF beats carry alt CNV (or fully random config) to prove the ports are shadowed.
  task automatic push_frame(input int ox, input int oy, input int cx, input int cy,
                            input int acx, input int acy, input bit rnd);
    int len;
    logic [DATA_W-1:0] d;
    for (int y = 0; y < oy; y++) begin
      len = ox;
      if (rnd && $urandom_range(0, 9) == 0) len = $urandom_range(1, ox + 1);
      for (int x = 0; x < len; x++) begin
        d = DATA_W'(y * 16 + x);
        if (rnd) d = d + DATA_W'($urandom_range(0, 255) << 16);
        if (x == 0 && y == 0)
          push(d, 1'b1, x == len - 1, ox, oy, cx, cy);
        else if (rnd)
          push(d, 1'b0, x == len - 1, $urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(0, 9), $urandom_range(0, 9));
        else
          push(d, 1'b0, x == len - 1, ox, oy, acx, acy);
      end
    end
  endtask

  task automatic run(input string name, input int vpct, input int rpct);
    int i = 0, cyc = 0, errs = 0;
    bit hold = 0;
    logic [25:0] held = '0;
    while ((i < bq.size() || eq.size() > 0) && cyc < 4000) begin
      @(negedge ACLK);
      cyc++;
      M_AXIS_TREADY = ($urandom_range(0, 99) < rpct);
      if (i < bq.size() && $urandom_range(0, 99) < vpct) begin
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA = bq[i].d; S_AXIS_TUSER = bq[i].u; S_AXIS_TLAST = bq[i].l;
        ORG_X = bq[i].ox; ORG_Y = bq[i].oy; CNV_X = bq[i].cx; CNV_Y = bq[i].cy;
      end else begin
        S_AXIS_TVALID = 1'b0;
      end
      #1;
      if (LINE_ERR) errs++;
      if (hold) chk({name, "_hold"}, {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA},
                    {1'b1, held});
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (eq.size() == 0) chk({name, "_extra"}, {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}, 26'h3ffffff);
        else chk({name, "_beat"}, {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}, eq.pop_front());
      end
      hold = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA};
      if (S_AXIS_TVALID && S_AXIS_TREADY) i++;
    end
    chk({name, "_sent"}, i, bq.size());
    chk({name, "_drain"}, eq.size(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0;
      M_AXIS_TREADY = 1'b1;
      #1;
      if (LINE_ERR) errs++;
    end
    chk({name, "_idle_vld"}, M_AXIS_TVALID, 0);
    chk({name, "_line_err"}, errs, exp_err);
    exp_err = 0;
    bq.delete();
    eq.delete();
  endtask

  initial begin
    #12;
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_tuser", M_AXIS_TUSER, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_line_err", LINE_ERR, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rst_tready", S_AXIS_TREADY, 1);

    push_frame(4, 4, 2, 2, 2, 2, 0);
    run("dec4x4", 100, 100);
    push_frame(5, 1, 3, 1, 3, 1, 0);
    run("ratio5to3", 100, 100);
    push_frame(4, 4, 4, 4, 4, 4, 0);
    run("bypass", 100, 100);
    push_frame(4, 4, 2, 2, 2, 2, 0);
    run("backpress", 60, 50);

    for (int x = 0; x < 3; x++) push(DATA_W'(x), x == 0, x == 2, 4, 1, 2, 1);
    for (int x = 0; x < 4; x++) push(DATA_W'(16 + x), 1'b0, x == 3, 4, 1, 2, 1);
    run("line_err", 100, 100);

    // new CNV on the ports mid-frame must only take effect at the next SOF
    push_frame(4, 4, 2, 2, 4, 4, 0);
    push_frame(4, 4, 4, 4, 4, 4, 0);
    run("cnv_change", 80, 80);

    for (int f = 0; f < 6; f++)
      push_frame($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, 7),
                 $urandom_range(0, 7), 0, 0, 1);
    run("random", 70, 60);

    // Stall one kept beat on the output, then reset mid-cycle.
    @(negedge ACLK);
    M_AXIS_TREADY = 1'b0;
    S_AXIS_TVALID = 1'b1; S_AXIS_TUSER = 1'b1; S_AXIS_TLAST = 1'b0;
    S_AXIS_TDATA = 24'h0000ab;
    ORG_X = 16'd1; ORG_Y = 16'd1; CNV_X = 16'd1; CNV_Y = 16'd1;
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    #1;
    chk("stall_vld", M_AXIS_TVALID, 1);
    chk("stall_data", {M_AXIS_TUSER, M_AXIS_TDATA}, {1'b1, 24'h0000ab});
    chk("stall_tready", S_AXIS_TREADY, 0);
    #2 ARESETN = 1'b0;
    #1;
    chk("midrst_vld", M_AXIS_TVALID, 0);
    chk("midrst_data", M_AXIS_TDATA, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    m_in = 0; m_sof = 0; m_x = 0; m_y = 0;
    for (int x = 0; x < 4; x++) push(DATA_W'(32 + x), 1'b0, x == 3, 4, 4, 2, 2);
    push_frame(4, 4, 2, 2, 2, 2, 0);
    run("after_rst", 90, 90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aq_axis_reduce_core.md
# aq_axis_reduce_core

Streaming image down-scaler that consumes the ORG_X/ORG_Y/CNV_X/CNV_Y register outputs of the AXI4-Lite reduce control block. It thins an AXI4-Stream video frame from ORG_X×ORG_Y to CNV_X×CNV_Y by nearest-neighbour decimation, using an error-accumulator (DDA) per axis. It sits between the video source stream and the downstream consumer, one pixel per beat, with a single registered output stage.

## Interface
- DATA_W, 24, pixel width (TDATA)
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous active-low (one clock; reset is asynchronous and active-low)
- ORG_X, ORG_Y  in  16 each  source width/height
- CNV_X, CNV_Y  in  16 each  target width/height
- S_AXIS_TDATA  in  DATA_W  input pixel
- S_AXIS_TUSER  in  1  start of frame (first pixel)
- S_AXIS_TLAST  in  1  end of line
- S_AXIS_TVALID  in  1; S_AXIS_TREADY  out  1
- M_AXIS_TDATA  out  DATA_W; M_AXIS_TUSER  out  1; M_AXIS_TLAST  out  1
- M_AXIS_TVALID  out  1; M_AXIS_TREADY  in  1
- LINE_ERR  out  1  one-cycle pulse: line length ≠ ORG_X

## Operation
- Beat accepted when S_AXIS_TVALID & S_AXIS_TREADY. S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY.
- Config: on accepted TUSER beat, ORG/CNV ports latch into shadow registers; that beat uses port values directly, all later beats use shadow values. Mid-frame port changes have no effect.
- Axis bypass: if CNV_X==0 or CNV_X>=ORG_X, every pixel passes in X (same for Y).
- X decision per accepted pixel: t = acc_x + CNV_X (17 bit); keep_x = t >= ORG_X; acc_x <= keep_x ? t-ORG_X : t. acc_x cleared on TUSER beat (before use) and after TLAST beat.
- Y decision at first pixel of each line: t = acc_y + CNV_Y; line_keep = t >= ORG_Y; acc_y updated likewise. acc_y cleared on TUSER beat.
- Pixel emitted iff keep_x & line_keep; dropped pixels are still accepted (consumed).
- Output TLAST = input TLAST of an emitted pixel. Output TUSER = 1 on the first emitted pixel after a TUSER beat (sof_pending flag, cleared on emit).
- x_cnt counts beats in line; TLAST with x_cnt+1 ≠ ORG_X (non-bypass or bypass alike) pulses LINE_ERR next cycle; accumulators still reset at TLAST.
- TUSER mid-frame: restart frame (clear acc_x, acc_y, x_cnt, re-latch config).

## Timing
- Latency: accepted kept pixel appears on M_AXIS 1 cycle later.
- Throughput: 1 pixel/cycle while M_AXIS_TREADY high.
- M_AXIS_TVALID, once high, holds with TDATA/TUSER/TLAST stable until M_AXIS_TREADY.
- Dropped beat with output stalled: still requires TREADY (no acceptance while output full and not draining).
- Reset values: M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TUSER=0, M_AXIS_TLAST=0, LINE_ERR=0, S_AXIS_TREADY=1 after reset deasserts; acc_x, acc_y, x_cnt, sof_pending, shadow regs = 0.
- Reset mid-frame: output beat discarded immediately; stream resumes only at next TUSER (pixels before it are accepted and dropped, sof_pending=0, line_keep=0).

## Test plan
- 4×4→2×2: ORG=4,4 CNV=2,2, pixel = y*16+x -> out 0x11(TUSER),0x13(TLAST),0x31,0x33(TLAST), 4 beats total.
- 5→3 X ratio: ORG_X=5,CNV_X=3,ORG_Y=CNV_Y=1, line 0..4 -> out x=1,3,4, TLAST on 4, TUSER on 1.
- Bypass: CNV=ORG=4,4 -> all 16 pixels pass unchanged, TUSER on 0x00, TLAST each x=3.
- Backpressure: 4×4→2×2 with M_AXIS_TREADY random 50% and TVALID gaps -> identical 4-beat sequence, no loss/duplicate, held data stable.
- Line error: ORG_X=4, send 3-pixel line with TLAST -> LINE_ERR pulses one cycle; next line decimates normally from acc_x=0.
- Reset mid-frame then new frame; and CNV change mid-frame -> no output until TUSER; change applies only to next frame.
